// File: rtl/snitch_icache_pkg.sv
// rtl/snitch_icache_pkg.sv - shared types for the instruction cache
package snitch_icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } sched_state_e;

endpackage

// File: rtl/rr_arb_tree.sv
// rtl/rr_arb_tree.sv - round-robin arbiter with optional grant lock and payload mux
// The search starts at the rr pointer; a handshake moves the pointer past the winner.
module rr_arb_tree #(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          LockIn    = 1'b0,
  parameter bit          ExtPrio   = 1'b0,
  parameter bit          AxiVldRdy = 1'b0,
  localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [IdxWidth-1:0]                rr_i,
  input  logic [NumIn-1:0]                   req_i,
  output logic [NumIn-1:0]                   gnt_o,
  input  logic [NumIn-1:0][DataWidth-1:0]    data_i,
  output logic                               req_o,
  input  logic                               gnt_i,
  output logic [DataWidth-1:0]               data_o,
  output logic [IdxWidth-1:0]                idx_o
);

  logic [IdxWidth-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, ptr, cand;
  logic                lock_q, lock_d, found;

  assign ptr = ExtPrio ? rr_i : rr_q;

  always_comb begin
    idx_o = ptr;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NumIn); k++) begin
      cand = IdxWidth'((int'(ptr) + k) % int'(NumIn));
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (LockIn && lock_q) idx_o = lock_idx_q;
  end

  assign req_o  = req_i[idx_o];
  assign data_o = data_i[idx_o];

  always_comb begin
    gnt_o        = '0;
    gnt_o[idx_o] = gnt_i & (req_o | ~AxiVldRdy);
  end

  // A stalled request pins the selection until it is accepted.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      rr_d   = '0;
      lock_d = 1'b0;
    end else if (req_o && gnt_i) begin
      rr_d   = (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + 1'b1;
      lock_d = 1'b0;
    end else if (LockIn && req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = idx_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/snitch_icache_lookup_sched.sv
// rtl/snitch_icache_lookup_sched.sv - shares the lookup request port among fetch ports
// Bounds in-flight lookups, routes responses by tag and drains before forwarding a flush.
module snitch_icache_lookup_sched
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_PORTS        = 4,
  parameter int unsigned FETCH_AW        = 48,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned PortIdxW       = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_valid_i,
  output logic                               flush_ready_o,
  input  logic [NR_PORTS-1:0][FETCH_AW-1:0]  req_addr_i,
  input  logic [NR_PORTS-1:0]                req_valid_i,
  output logic [NR_PORTS-1:0]                req_ready_o,
  output logic [FETCH_AW-1:0]                lk_addr_o,
  output logic [PortIdxW-1:0]                lk_id_o,
  output logic                               lk_valid_o,
  input  logic                               lk_ready_i,
  output logic                               lk_flush_valid_o,
  input  logic                               lk_flush_ready_i,
  input  logic [PortIdxW-1:0]                lk_rsp_id_i,
  input  logic                               lk_rsp_valid_i,
  output logic                               lk_rsp_ready_o,
  output logic [NR_PORTS-1:0]                rsp_valid_o,
  input  logic [NR_PORTS-1:0]                rsp_ready_i
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

  sched_state_e        state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                lock_q, lock_d;
  logic                eligible, lk_hs, rsp_hs, id_legal;
  logic [NR_PORTS-1:0] req_gated;

  // A locked request must stay visible even while draining or full.
  assign eligible  = ((state_q == IDLE) && (cnt_q < MaxCnt)) || lock_q;
  assign req_gated = req_valid_i & {NR_PORTS{eligible}};

  rr_arb_tree #(
    .NumIn     (NR_PORTS),
    .DataWidth (FETCH_AW),
    .LockIn    (1'b1),
    .ExtPrio   (1'b0),
    .AxiVldRdy (1'b1)
  ) i_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .rr_i    ('0),
    .req_i   (req_gated),
    .gnt_o   (req_ready_o),
    .data_i  (req_addr_i),
    .req_o   (lk_valid_o),
    .gnt_i   (lk_ready_i),
    .data_o  (lk_addr_o),
    .idx_o   (lk_id_o)
  );

  assign id_legal = 32'(lk_rsp_id_i) < NR_PORTS;

  always_comb begin
    rsp_valid_o    = '0;
    lk_rsp_ready_o = 1'b0;
    if (id_legal) begin
      rsp_valid_o[lk_rsp_id_i] = lk_rsp_valid_i;
      lk_rsp_ready_o           = rsp_ready_i[lk_rsp_id_i];
    end
  end

  assign lk_hs  = lk_valid_o & lk_ready_i;
  assign rsp_hs = lk_rsp_valid_i & lk_rsp_ready_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({lk_hs, rsp_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    lock_d = lk_hs ? 1'b0 : (lk_valid_o ? 1'b1 : lock_q);
  end

  always_comb begin
    state_d          = state_q;
    lk_flush_valid_o = 1'b0;
    flush_ready_o    = 1'b0;
    case (state_q)
      IDLE:  if (flush_valid_i) state_d = DRAIN;
      DRAIN: if (!lock_q && (cnt_q == '0)) state_d = FLUSH;
      FLUSH: begin
        lk_flush_valid_o = 1'b1;
        flush_ready_o    = lk_flush_ready_i;
        if (lk_flush_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) lk_rsp_valid_i |-> id_legal);
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(lk_hs && !rsp_hs && (cnt_q == MaxCnt)));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(rsp_hs && !lk_hs && (cnt_q == '0)));

endmodule

// File: tb/tb_snitch_icache_lookup_sched.sv
// tb/tb_snitch_icache_lookup_sched.sv - self-checking bench for the lookup scheduler
module tb_snitch_icache_lookup_sched;

  localparam int NP = 4;
  localparam int AW = 48;
  localparam int MO = 4;
  localparam int IW = 2;
  localparam int GRANTING = 0;
  localparam int DRAINING = 1;
  localparam int FLUSHING = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_valid, flush_ready, lk_flush_valid, lk_flush_ready;
  logic [NP-1:0][AW-1:0] req_addr;
  logic [NP-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [AW-1:0] lk_addr;
  logic [IW-1:0] lk_id, lk_rsp_id;
  logic lk_valid, lk_ready, lk_rsp_valid, lk_rsp_ready;

  always #5 clk = ~clk;

  snitch_icache_lookup_sched #(.NR_PORTS(NP), .FETCH_AW(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .flush_valid_i(flush_valid), .flush_ready_o(flush_ready),
    .req_addr_i(req_addr), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .lk_addr_o(lk_addr), .lk_id_o(lk_id), .lk_valid_o(lk_valid), .lk_ready_i(lk_ready),
    .lk_flush_valid_o(lk_flush_valid), .lk_flush_ready_i(lk_flush_ready),
    .lk_rsp_id_i(lk_rsp_id), .lk_rsp_valid_i(lk_rsp_valid), .lk_rsp_ready_o(lk_rsp_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready)
  );

  int n_total = 0;
  int n_pass = 0;

  // Reference model: scheduler phase, outstanding count, rr pointer and pending lock
  int m_phase, m_cnt, m_rr, m_lock_port;
  bit m_locked;
  bit e_valid, e_rsp_ready, e_lkf, e_fr;
  int e_id;
  logic [AW-1:0] e_addr;
  logic [NP-1:0] e_req_ready, e_rsp_valid;

  function automatic void model_reset();
    m_phase = GRANTING; m_cnt = 0; m_rr = 0; m_lock_port = 0; m_locked = 0;
    e_valid = 0; e_rsp_ready = 0; e_lkf = 0; e_fr = 0; e_id = 0;
    e_addr = '0; e_req_ready = '0; e_rsp_valid = '0;
  endfunction

  function automatic void model_eval();
    bit elig;
    int p;
    elig = (m_phase == GRANTING && m_cnt < MO) || m_locked;
    e_valid = 0;
    e_id = 0;
    if (m_locked) begin
      e_id = m_lock_port;
      e_valid = req_valid[m_lock_port];
    end else if (elig) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_rr + k) % NP;
        if (!e_valid && req_valid[p]) begin
          e_valid = 1;
          e_id = p;
        end
      end
    end
    e_addr = req_addr[e_id];
    e_req_ready = '0;
    if (e_valid && lk_ready) e_req_ready[e_id] = 1'b1;
    e_rsp_valid = '0;
    if (lk_rsp_valid) e_rsp_valid[lk_rsp_id] = 1'b1;
    e_rsp_ready = rsp_ready[lk_rsp_id];
    e_lkf = (m_phase == FLUSHING);
    e_fr = e_lkf && lk_flush_ready;
  endfunction

  function automatic void model_clock();
    bit lk_hs, rsp_hs;
    lk_hs = e_valid && lk_ready;
    rsp_hs = lk_rsp_valid && e_rsp_ready;
    case (m_phase)
      GRANTING: if (flush_valid) m_phase = DRAINING;
      DRAINING: if (!m_locked && m_cnt == 0) m_phase = FLUSHING;
      default:  if (lk_flush_ready) m_phase = GRANTING;
    endcase
    m_cnt = m_cnt + int'(lk_hs) - int'(rsp_hs);
    if (lk_hs) begin
      m_rr = (e_id + 1) % NP;
      m_locked = 0;
    end else if (e_valid) begin
      m_locked = 1;
      m_lock_port = e_id;
    end
  endfunction

  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    lk_ready = 1'b0;
    for (int g = 0; g < 16 && m_cnt > 0; g++) begin
      lk_rsp_valid = 1'b1; lk_rsp_id = IW'(g % NP); rsp_ready = '1;
      settle();
      tick();
    end
    lk_rsp_valid = 1'b0;
    rsp_ready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_valid = 0; lk_flush_ready = 0; req_valid = '0; req_addr = '0;
    lk_ready = 0; lk_rsp_id = '0; lk_rsp_valid = 0; rsp_ready = '0;
    model_reset();
    #1;
    settle();
    n_total++;
    if ({lk_valid, lk_flush_valid, flush_ready, lk_rsp_ready} !== 4'b0 || req_ready !== '0 || rsp_valid !== '0)
      $display("FAIL reset_outputs: got lk_valid=%b lk_flush_valid=%b flush_ready=%b lk_rsp_ready=%b req_ready=%b rsp_valid=%b, expected all 0",
               lk_valid, lk_flush_valid, flush_ready, lk_rsp_ready, req_ready, rsp_valid);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_addr[0] = 48'h1000; lk_ready = 1;
    settle();
    n_total++;
    if (lk_valid !== 1'b1 || lk_addr !== 48'h1000 || lk_id !== 2'd0)
      $display("FAIL single_req: got valid=%b addr=%h id=%0d, expected valid=1 addr=1000 id=0", lk_valid, lk_addr, lk_id);
    else n_pass++;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected 0001", req_ready);
    else n_pass++;
    tick();
    req_valid = '0; lk_rsp_valid = 1; lk_rsp_id = 2'd0; rsp_ready = 4'b0001;
    settle();
    n_total++;
    if (rsp_valid !== 4'b0001 || lk_rsp_ready !== 1'b1)
      $display("FAIL single_rsp: got rsp_valid=%b lk_rsp_ready=%b, expected 0001 and 1", rsp_valid, lk_rsp_ready);
    else n_pass++;
    tick();
    lk_rsp_valid = 0; rsp_ready = '0;
  endtask

  task automatic test_rr_order();
    int start, expid, prev;
    logic [AW-1:0] expaddr;
    start = m_rr; prev = 0;
    req_valid = '1; lk_ready = 1;
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < NP; p++) req_addr[p] = AW'(32'h2000 + p * 16 + k);
      if (k > 0) begin lk_rsp_valid = 1; lk_rsp_id = IW'(prev); rsp_ready = '1; end
      settle();
      expid = (start + k) % NP;
      expaddr = AW'(32'h2000 + expid * 16 + k);
      n_total++;
      if (lk_valid !== 1'b1 || lk_id !== IW'(expid) || lk_addr !== expaddr)
        $display("FAIL rr_order step %0d: got valid=%b id=%0d addr=%h, expected valid=1 id=%0d addr=%h",
                 k, lk_valid, lk_id, lk_addr, expid, expaddr);
      else n_pass++;
      prev = expid;
      tick();
    end
    req_valid = '0; lk_rsp_valid = 1; lk_rsp_id = IW'(prev); rsp_ready = '1;
    settle();
    tick();
    lk_rsp_valid = 0; rsp_ready = '0;
  endtask

  task automatic test_lock();
    req_valid = 4'b0100; req_addr[2] = 48'hABCD00; req_addr[0] = 48'h5555; req_addr[1] = 48'h7777;
    lk_ready = 0;
    for (int k = 0; k < 5; k++) begin
      if (k >= 3) req_valid = 4'b0111;
      if (k == 4) lk_ready = 1;
      settle();
      n_total++;
      if (lk_valid !== 1'b1 || lk_id !== 2'd2 || lk_addr !== 48'hABCD00)
        $display("FAIL lock_hold step %0d: got valid=%b id=%0d addr=%h, expected valid=1 id=2 addr=abcd00", k, lk_valid, lk_id, lk_addr);
      else n_pass++;
      tick();
    end
    req_valid = '1; lk_ready = 1;
    settle();
    n_total++;
    if (lk_id !== 2'd3) $display("FAIL lock_rr_after: got id=%0d expected 3", lk_id);
    else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_max_outstanding();
    req_valid = 4'b0001; req_addr[0] = 48'h3000; lk_ready = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_total++;
      if (lk_valid !== 1'b1) $display("FAIL max_fill %0d: got lk_valid=%b expected 1", k, lk_valid);
      else n_pass++;
      tick();
    end
    settle();
    n_total++;
    if (lk_valid !== 1'b0 || req_ready !== '0)
      $display("FAIL max_block: got lk_valid=%b req_ready=%b expected 0 and 0000", lk_valid, req_ready);
    else n_pass++;
    tick();
    lk_rsp_valid = 1; lk_rsp_id = 2'd1; rsp_ready = '1;
    settle();
    n_total++;
    if (lk_valid !== 1'b0) $display("FAIL max_rsp_cycle: got lk_valid=%b expected 0", lk_valid);
    else n_pass++;
    tick();
    lk_rsp_valid = 0; rsp_ready = '0;
    settle();
    n_total++;
    if (lk_valid !== 1'b1 || req_ready !== 4'b0001)
      $display("FAIL max_reopen: got lk_valid=%b req_ready=%b expected 1 and 0001", lk_valid, req_ready);
    else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_flush();
    req_valid = 4'b0010; req_addr[1] = 48'h4000; lk_ready = 1;
    settle(); tick();
    settle(); tick();
    req_valid = '0; flush_valid = 1; lk_flush_ready = 0;
    settle(); tick();
    req_valid = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      lk_rsp_valid = (k == 3 || k == 5); lk_rsp_id = 2'd1; rsp_ready = '1;
      settle();
      n_total++;
      if (lk_valid !== 1'b0 || lk_flush_valid !== 1'b0)
        $display("FAIL flush_drain %0d: got lk_valid=%b lk_flush_valid=%b expected 0 and 0", k, lk_valid, lk_flush_valid);
      else n_pass++;
      tick();
    end
    lk_rsp_valid = 0; lk_flush_ready = 1;
    settle();
    n_total++;
    if (lk_flush_valid !== 1'b1 || flush_ready !== 1'b1 || lk_valid !== 1'b0)
      $display("FAIL flush_fwd: got lk_flush_valid=%b flush_ready=%b lk_valid=%b expected 1 1 0", lk_flush_valid, flush_ready, lk_valid);
    else n_pass++;
    tick();
    flush_valid = 0;
    settle();
    n_total++;
    if (lk_flush_valid !== 1'b0 || flush_ready !== 1'b0 || lk_valid !== 1'b1)
      $display("FAIL flush_done: got lk_flush_valid=%b flush_ready=%b lk_valid=%b expected 0 0 1", lk_flush_valid, flush_ready, lk_valid);
    else n_pass++;
    tick();
    lk_flush_ready = 0;
    drain();
    flush_valid = 1;
    for (int k = 0; k < 5; k++) begin
      lk_flush_ready = (k == 4);
      settle();
      n_total++;
      if (lk_flush_valid !== (k >= 2) || flush_ready !== (k == 4))
        $display("FAIL flush_latency +%0d: got lk_flush_valid=%b flush_ready=%b expected %b %b",
                 k, lk_flush_valid, flush_ready, (k >= 2), (k == 4));
      else n_pass++;
      tick();
    end
    flush_valid = 0; lk_flush_ready = 0;
  endtask

  task automatic test_async_reset();
    lk_ready = 1;
    req_valid = 4'b0001; settle(); tick();
    req_valid = 4'b0010; settle(); tick();
    req_valid = 4'b1000; settle(); tick();
    req_valid = 4'b0100; req_addr[2] = 48'h9000; lk_ready = 0;
    settle(); tick();
    flush_valid = 1;
    settle(); tick();
    settle();
    n_total++;
    if (lk_valid !== 1'b1 || lk_id !== 2'd2 || lk_flush_valid !== 1'b0)
      $display("FAIL drain_locked: got lk_valid=%b id=%0d lk_flush_valid=%b expected 1 2 0", lk_valid, lk_id, lk_flush_valid);
    else n_pass++;
    #1;
    rst_n = 0; req_valid = '0; flush_valid = 0;
    model_reset();
    #1;
    n_total++;
    if ({lk_valid, lk_flush_valid, flush_ready, lk_rsp_ready} !== 4'b0 || req_ready !== '0 || rsp_valid !== '0)
      $display("FAIL async_reset_outputs: got lk_valid=%b lk_flush_valid=%b flush_ready=%b lk_rsp_ready=%b req_ready=%b rsp_valid=%b",
               lk_valid, lk_flush_valid, flush_ready, lk_rsp_ready, req_ready, rsp_valid);
    else n_pass++;
    req_valid = '1;
    #1;
    n_total++;
    if (lk_valid !== 1'b1 || lk_id !== 2'd0)
      $display("FAIL async_reset_state: got lk_valid=%b id=%0d expected 1 and 0", lk_valid, lk_id);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1; req_valid = '0;
    model_eval();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(req_valid[p] && !e_req_ready[p])) begin
          req_valid[p] = ($urandom_range(0, 99) < 50);
          req_addr[p] = AW'({$urandom(), $urandom()});
        end
      end
      lk_ready = ($urandom_range(0, 99) < 70);
      lk_rsp_valid = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
      lk_rsp_id = IW'($urandom_range(0, NP - 1));
      rsp_ready = NP'($urandom());
      if (flush_valid && e_fr) flush_valid = 0;
      else if (!flush_valid && m_phase == GRANTING) flush_valid = ($urandom_range(0, 99) < 3);
      lk_flush_ready = ($urandom_range(0, 1) == 1);
      settle();
      n_total++;
      if (lk_valid !== e_valid) $display("FAIL rnd_lk_valid cyc %0d: got %b expected %b", c, lk_valid, e_valid);
      else n_pass++;
      if (e_valid) begin
        n_total++;
        if (lk_id !== IW'(e_id) || lk_addr !== e_addr)
          $display("FAIL rnd_lk_req cyc %0d: got id=%0d addr=%h expected id=%0d addr=%h", c, lk_id, lk_addr, e_id, e_addr);
        else n_pass++;
      end
      n_total++;
      if (req_ready !== e_req_ready) $display("FAIL rnd_req_ready cyc %0d: got %b expected %b", c, req_ready, e_req_ready);
      else n_pass++;
      n_total++;
      if (rsp_valid !== e_rsp_valid || lk_rsp_ready !== e_rsp_ready)
        $display("FAIL rnd_rsp cyc %0d: got rsp_valid=%b lk_rsp_ready=%b expected %b %b", c, rsp_valid, lk_rsp_ready, e_rsp_valid, e_rsp_ready);
      else n_pass++;
      n_total++;
      if (lk_flush_valid !== e_lkf || flush_ready !== e_fr)
        $display("FAIL rnd_flush cyc %0d: got lk_flush_valid=%b flush_ready=%b expected %b %b", c, lk_flush_valid, flush_ready, e_lkf, e_fr);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_lock();
    test_max_outstanding();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/snitch_icache_lookup_sched.md
# snitch_icache_lookup_sched

Request scheduler in front of the serial instruction-cache lookup. It shares the lookup's single request port among NR_PORTS fetch requesters with round-robin arbitration and tags each request with its port index. It routes lookup responses back to the issuing port and bounds the number of in-flight lookups. It also sequences flushes: new grants stop, the pipeline drains, and only then is the flush forwarded to the lookup.

## Interface
- NR_PORTS, 4: number of requesters, ≥1.
- FETCH_AW, 48: fetch address width.
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered lookups, ≥1.
- PortIdxW (localparam), max(1, $clog2(NR_PORTS)): width of the port tag.
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- flush_valid_i  in  1  upstream flush request.
- flush_ready_o  out  1  upstream flush completion.
- req_addr_i  in  NR_PORTS×FETCH_AW  per-port fetch address.
- req_valid_i  in  NR_PORTS  per-port request valid.
- req_ready_o  out  NR_PORTS  per-port request ready.
- lk_addr_o  out  FETCH_AW  address to the lookup.
- lk_id_o  out  PortIdxW  port tag to the lookup.
- lk_valid_o  out  1  request valid to the lookup.
- lk_ready_i  in  1  lookup accepts the request.
- lk_flush_valid_o  out  1  flush request to the lookup.
- lk_flush_ready_i  in  1  lookup accepts the flush.
- lk_rsp_id_i  in  PortIdxW  tag of the lookup response.
- lk_rsp_valid_i  in  1  lookup response valid.
- lk_rsp_ready_o  out  1  response ready back to the lookup.
- rsp_valid_o  out  NR_PORTS  per-port response valid. Hit, data and error are broadcast by the parent, not by this block.
- rsp_ready_i  in  NR_PORTS  per-port response ready.

## Operation
- FSM states:
  - IDLE: grants allowed. On flush_valid_i, go to DRAIN.
  - DRAIN: no new grants. When lock==0 and cnt==0, go to FLUSH.
  - FLUSH: lk_flush_valid_o=1 and flush_ready_o=lk_flush_ready_i. On that handshake, go to IDLE.
- Grant eligibility: state==IDLE and cnt<MAX_OUTSTANDING, or a locked request is pending.
- Round-robin arbitration:
  - The search starts at pointer rr; the lowest eligible index ≥ rr wins, wrapping to 0.
  - On an lk handshake, rr ← grant+1 mod NR_PORTS.
  - rr is unchanged when there is no handshake.
- Lock:
  - If lk_valid_o is high and lk_ready_i is low, set lock=1 and hold the granted index.
  - While locked, lk_addr_o, lk_id_o and lk_valid_o stay stable regardless of the FSM state, cnt, or other ports' valids.
  - Lock clears on the handshake.
- Request outputs: lk_addr_o and lk_id_o come from the granted port. req_ready_o[g] = lk_ready_i & granted(g); all other ports get 0.
- Response routing:
  - rsp_valid_o[lk_rsp_id_i] = lk_rsp_valid_i; all other bits 0.
  - lk_rsp_ready_o = rsp_ready_i[lk_rsp_id_i].
  - An id ≥ NR_PORTS is illegal and asserted in simulation.
- Outstanding counter cnt, width $clog2(MAX_OUTSTANDING+1):
  - +1 on an lk request handshake, −1 on a response handshake.
  - Both in the same cycle: unchanged.
  - Overflow and underflow are simulation assertions.
- Flush requests arriving in DRAIN or FLUSH are the same request held high; flush_valid_i must stay high until flush_ready_o.

## Timing
- Request path is combinational: req_valid_i to lk_valid_o, and lk_ready_i to req_ready_o, both 0 cycles.
- Response path is combinational: 0 cycles.
- A grant blocked by cnt==MAX_OUTSTANDING becomes eligible the cycle after the decrementing response handshake.
- Flush latency from flush_valid_i rising in IDLE with cnt==0 and no lock:
  - DRAIN at +1, FLUSH at +2.
  - lk_flush_valid_o is high from +2.
  - flush_ready_o is in the same cycle as lk_flush_ready_i.
- Reset values:
  - State IDLE, rr=0, cnt=0, lock=0.
  - All valid/ready outputs 0: lk_valid_o, lk_flush_valid_o, flush_ready_o, req_ready_o, rsp_valid_o, lk_rsp_ready_o.
- Reset mid-operation abandons in-flight lookups. The parent resets the lookup on the same rst_ni.
- In FLUSH with lk_flush_ready_i=0 the block waits indefinitely, with no timeout.

## Structure
- Add typedef sched_state_e {IDLE, DRAIN, FLUSH} to snitch_icache_pkg.
- One sub-module: rr_arb_tree from common_cells.
  - Settings: LockIn=1, ExtPrio=0, AxiVldRdy=1.
  - Its req inputs are gated by the eligibility term.
  - Its data field carries the address; idx_o is lk_id_o.
- The FSM, counter and response demux are local to this module.

## Test plan
- Single port 0 request at addr 0x1000 with lk_ready_i=1 → lk_valid_o, lk_addr_o=0x1000 and lk_id_o=0 in the same cycle; cnt=1; response with id 0 → rsp_valid_o=4'b0001 and cnt=0.
- All 4 ports continuously valid, lk_ready_i=1, responses returned immediately → grants in order 0,1,2,3,0,… with no port skipped.
- lk_ready_i=0 for 3 cycles with port 2 granted, then port 0 also raises valid → lk_id_o stays 2 and lk_addr_o stays stable until the handshake; then rr=3.
- MAX_OUTSTANDING=4 and 4 accepted requests with no response → lk_valid_o=0 on the fifth request; one response → next request granted the following cycle.
- flush_valid_i with cnt=2 → no grants, lk_flush_valid_o=0 until both responses return; then lk_flush_valid_o=1, with lk_flush_ready_i=1 → flush_ready_o=1 for one cycle and state back to IDLE.
- rst_ni asserted with cnt=3, lock=1 and state DRAIN → all outputs 0, cnt=0, rr=0 and state IDLE immediately (asynchronous reset).
